// File: rtl/divisor_sequencial_if.sv
// Operand/result bundle for the sequential divider.
// Handshake: Inicio is honoured only while the divider is idle (no queueing, no
// backpressure); Pronto pulses for exactly one cycle when Quociente/Resto/DivZero update.
interface divisor_sequencial_if #(
    parameter int WIDTH = 4
);
    logic             Inicio;
    logic [WIDTH-1:0] Dividendo;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quociente;
    logic [WIDTH-1:0] Resto;
    logic             Pronto;
    logic             Ocupado;
    logic             DivZero;
    logic [1:0]       dbg_state;

    modport master (
        output Inicio, Dividendo, Divisor,
        input  Quociente, Resto, Pronto, Ocupado, DivZero, dbg_state
    );

    modport slave (
        input  Inicio, Dividendo, Divisor,
        output Quociente, Resto, Pronto, Ocupado, DivZero, dbg_state
    );
endinterface

// File: rtl/divisor_sequencial.sv
// Unsigned restoring shift-subtract divider: one quotient bit per clock over WIDTH cycles.
// Divide-by-zero returns all-ones quotient and the dividend as remainder.
module divisor_sequencial #(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    divisor_sequencial_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quoc;
    logic [WIDTH-1:0] r_resto;
    logic             r_pronto;
    logic             r_ocupado;
    logic             r_divzero;

    logic [WIDTH-1:0] w_shift_lo;
    logic             w_ge;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;

    // The shifted partial remainder is WIDTH+1 bits wide; its top bit is r_r's MSB.
    // When that bit is set the value already exceeds any divisor, and the true
    // difference is below the divisor, so a WIDTH-bit subtract is exact.
    assign w_shift_lo = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_ge       = r_r[WIDTH-1] | (w_shift_lo >= r_b);
    assign w_r_next   = w_ge ? (w_shift_lo - r_b) : w_shift_lo;
    assign w_q_next   = {r_q[WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_r       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_quoc    <= '0;
            r_resto   <= '0;
            r_pronto  <= 1'b0;
            r_ocupado <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pronto <= 1'b0;
                    if (bus.Inicio) begin
                        if (bus.Divisor != '0) begin
                            r_q       <= bus.Dividendo;
                            r_r       <= '0;
                            r_b       <= bus.Divisor;
                            r_cnt     <= CW'(WIDTH);
                            r_ocupado <= 1'b1;
                            r_state   <= S_CALC;
                        end else begin
                            r_quoc    <= '1;
                            r_resto   <= bus.Dividendo;
                            r_divzero <= 1'b1;
                            r_pronto  <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_quoc    <= w_q_next;
                        r_resto   <= w_r_next;
                        r_divzero <= 1'b0;
                        r_pronto  <= 1'b1;
                        r_ocupado <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_pronto <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_pronto  <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Quociente = r_quoc;
    assign bus.Resto     = r_resto;
    assign bus.Pronto    = r_pronto;
    assign bus.Ocupado   = r_ocupado;
    assign bus.DivZero   = r_divzero;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed testbench for divisor_sequencial (WIDTH=4): timing, hold, divide-by-zero,
// back-to-back starts, mid-operation reset and a full operand sweep.
module tb_divisor_sequencial;
    localparam int WIDTH = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    divisor_sequencial_if #(.WIDTH(WIDTH)) bus ();

    divisor_sequencial #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        bus.Inicio    = 1'b1;
        bus.Dividendo = a;
        bus.Divisor   = b;
        step();
        bus.Inicio = 1'b0;
    endtask

    task automatic wait_pronto(output bit ok);
        int i;
        ok = 1'b0;
        i = 0;
        while (!ok && i < 20) begin
            if (bus.Pronto === 1'b1) ok = 1'b1;
            else begin
                step();
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Inicio = 1'b0;
        bus.Dividendo = '0;
        bus.Divisor = '0;
        step();
        step();
        n_checks++;
        if ({bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado, bus.DivZero, bus.dbg_state} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got Q=%0d R=%0d P=%b O=%b DZ=%b st=%0d, want all zero",
                     bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado, bus.DivZero, bus.dbg_state);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({bus.Pronto, bus.dbg_state} !== {1'b0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL reset_idle: got P=%b st=%0d, want P=0 st=0", bus.Pronto, bus.dbg_state);
        end
    endtask

    task automatic test_basic_13_3();
        start_op(4'd13, 4'd3);
        for (int e = 0; e < 4; e++) begin
            n_checks++;
            if ({bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL basic_calc_E%0d: got Q=%0d R=%0d P=%b O=%b, want Q=0 R=0 P=0 O=1",
                         e, bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado);
            end
            step();
        end
        n_checks++;
        if ({bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado, bus.DivZero} !== {4'd4, 4'd1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result_E4: got Q=%0d R=%0d P=%b O=%b DZ=%b, want Q=4 R=1 P=1 O=0 DZ=0",
                     bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado, bus.DivZero);
        end
        step();
        n_checks++;
        if ({bus.Pronto, bus.Ocupado, bus.dbg_state} !== {1'b0, 1'b0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL basic_after_E5: got P=%b O=%b st=%0d, want P=0 O=0 st=0",
                     bus.Pronto, bus.Ocupado, bus.dbg_state);
        end
    endtask

    task automatic test_outputs_hold();
        bit ok;
        start_op(4'd15, 4'd15);
        wait_pronto(ok);
        n_checks++;
        if (!ok || {bus.Quociente, bus.Resto} !== {4'd1, 4'd0}) begin
            n_fail++;
            $display("FAIL hold_15_15: ok=%b got Q=%0d R=%0d, want Q=1 R=0", ok, bus.Quociente, bus.Resto);
        end
        step();
        start_op(4'd2, 4'd10);
        for (int e = 0; e < 4; e++) begin
            n_checks++;
            if ({bus.Quociente, bus.Resto, bus.Ocupado, bus.Pronto} !== {4'd1, 4'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_during_calc_E%0d: got Q=%0d R=%0d O=%b P=%b, want Q=1 R=0 O=1 P=0",
                         e, bus.Quociente, bus.Resto, bus.Ocupado, bus.Pronto);
            end
            step();
        end
        n_checks++;
        if ({bus.Quociente, bus.Resto, bus.Pronto} !== {4'd0, 4'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_2_10: got Q=%0d R=%0d P=%b, want Q=0 R=2 P=1",
                     bus.Quociente, bus.Resto, bus.Pronto);
        end
        step();
    endtask

    task automatic test_div_zero();
        start_op(4'd7, 4'd0);
        n_checks++;
        if ({bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado, bus.DivZero} !== {4'd15, 4'd7, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL divzero_E0: got Q=%0d R=%0d P=%b O=%b DZ=%b, want Q=15 R=7 P=1 O=0 DZ=1",
                     bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado, bus.DivZero);
        end
        step();
        n_checks++;
        if ({bus.Pronto, bus.DivZero, bus.dbg_state} !== {1'b0, 1'b1, ST_IDLE}) begin
            n_fail++;
            $display("FAIL divzero_E1: got P=%b DZ=%b st=%0d, want P=0 DZ=1 st=0",
                     bus.Pronto, bus.DivZero, bus.dbg_state);
        end
        start_op(4'd9, 4'd2);
        for (int e = 0; e < 4; e++) begin
            n_checks++;
            if ({bus.DivZero, bus.Quociente, bus.Resto} !== {1'b1, 4'd15, 4'd7}) begin
                n_fail++;
                $display("FAIL divzero_held_E%0d: got DZ=%b Q=%0d R=%0d, want DZ=1 Q=15 R=7",
                         e, bus.DivZero, bus.Quociente, bus.Resto);
            end
            step();
        end
        n_checks++;
        if ({bus.Quociente, bus.Resto, bus.Pronto, bus.DivZero} !== {4'd4, 4'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL divzero_clear_9_2: got Q=%0d R=%0d P=%b DZ=%b, want Q=4 R=1 P=1 DZ=0",
                     bus.Quociente, bus.Resto, bus.Pronto, bus.DivZero);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int pulses;
        bus.Inicio    = 1'b1;
        bus.Dividendo = 4'd13;
        bus.Divisor   = 4'd3;
        step();
        bus.Dividendo = 4'd6;
        bus.Divisor   = 4'd4;
        pulses = 0;
        for (int e = 1; e < 4; e++) begin
            step();
            if (bus.Pronto === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL b2b_early_pronto: got %0d pulses in E1..E3, want 0", pulses);
        end
        step();
        n_checks++;
        if ({bus.Pronto, bus.Quociente, bus.Resto} !== {1'b1, 4'd4, 4'd1}) begin
            n_fail++;
            $display("FAIL b2b_first_E4: got P=%b Q=%0d R=%0d, want P=1 Q=4 R=1",
                     bus.Pronto, bus.Quociente, bus.Resto);
        end
        step();
        n_checks++;
        if ({bus.Pronto, bus.Ocupado, bus.dbg_state} !== {1'b0, 1'b0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL b2b_E5_ignored: got P=%b O=%b st=%0d, want P=0 O=0 st=0",
                     bus.Pronto, bus.Ocupado, bus.dbg_state);
        end
        step();
        n_checks++;
        if ({bus.Ocupado, bus.dbg_state} !== {1'b1, ST_CALC}) begin
            n_fail++;
            $display("FAIL b2b_restart_E6: got O=%b st=%0d, want O=1 st=1", bus.Ocupado, bus.dbg_state);
        end
        bus.Dividendo = 4'd15;
        bus.Divisor   = 4'd1;
        for (int e = 7; e < 11; e++) step();
        n_checks++;
        if ({bus.Pronto, bus.Quociente, bus.Resto} !== {1'b1, 4'd1, 4'd2}) begin
            n_fail++;
            $display("FAIL b2b_second_E10: got P=%b Q=%0d R=%0d, want P=1 Q=1 R=2",
                     bus.Pronto, bus.Quociente, bus.Resto);
        end
        step();
        step();
        bus.Inicio = 1'b0;
        wait_pronto(ok);
        n_checks++;
        if (!ok || {bus.Quociente, bus.Resto} !== {4'd15, 4'd0}) begin
            n_fail++;
            $display("FAIL b2b_third_15_1: ok=%b got Q=%0d R=%0d, want Q=15 R=0", ok, bus.Quociente, bus.Resto);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int pulses;
        start_op(4'd14, 4'd3);
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado, bus.DivZero, bus.dbg_state} !== 13'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got Q=%0d R=%0d P=%b O=%b DZ=%b st=%0d, want all zero",
                     bus.Quociente, bus.Resto, bus.Pronto, bus.Ocupado, bus.DivZero, bus.dbg_state);
        end
        rst_n = 1'b1;
        pulses = 0;
        for (int e = 0; e < 8; e++) begin
            step();
            if (bus.Pronto === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || bus.dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midreset_no_pronto: got %0d pulses st=%0d, want 0 pulses st=0", pulses, bus.dbg_state);
        end
        start_op(4'd12, 4'd5);
        wait_pronto(ok);
        n_checks++;
        if (!ok || {bus.Quociente, bus.Resto, bus.DivZero} !== {4'd2, 4'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_12_5: ok=%b got Q=%0d R=%0d DZ=%b, want Q=2 R=2 DZ=0",
                     ok, bus.Quociente, bus.Resto, bus.DivZero);
        end
        step();
    endtask

    task automatic test_sweep();
        bit ok;
        logic [3:0] a4, b4, eq, er;
        logic ed;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                a4 = 4'(a);
                b4 = 4'(b);
                if (b == 0) begin
                    eq = 4'd15;
                    er = a4;
                    ed = 1'b1;
                end else begin
                    eq = 4'(a / b);
                    er = 4'(a % b);
                    ed = 1'b0;
                end
                start_op(a4, b4);
                wait_pronto(ok);
                n_checks++;
                if (!ok || {bus.Quociente, bus.Resto, bus.DivZero} !== {eq, er, ed}) begin
                    n_fail++;
                    $display("FAIL sweep_%0d_%0d: ok=%b got Q=%0d R=%0d DZ=%b, want Q=%0d R=%0d DZ=%b",
                             a, b, ok, bus.Quociente, bus.Resto, bus.DivZero, eq, er, ed);
                end
                step();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_13_3();
        test_outputs_hold();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
